lc3b_mem_sequencer: RTL

- Parametrised memory-access sequencer between the multicycle control FSM and the memory port.
- Replaces the per-opcode strobe-and-wait states (fetch/ldr/str/ldb/stb/ldi/sti/trap-vector) with one reusable engine.
- Control issues one request: read, write, read-indirect or write-indirect, word or byte. The sequencer drives mem_read/mem_write and byte enables, waits on mem_resp, and returns one response.
- New over the existing control: width generalisation, byte-lane generalisation, and a bounded wait with error reporting.

---
 rtl/lc3b_mem_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer: one control request -> optional pointer read -> one memory access -> one-cycle response.
// Response 2 cycles after acceptance (3 if indirect) plus memory wait cycles; req_ready only while IDLE.
`timescale 1ns/1ps
module lc3b_mem_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic                req_byte,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [LW-1:0]       lane;
  logic [ADDR_W-1:0]   addr_aligned;
  logic [NB-1:0]       lane_mask;
  logic                tmo_hit;

  assign lane         = addr_q[LW-1:0];
  assign addr_aligned = addr_q & ~ADDR_W'(NB - 1);
  assign lane_mask    = NB'(1) << lane;
  // mem_resp on the limit cycle takes priority over the timeout
  assign tmo_hit      = (TIMEOUT > 0) && !mem_resp && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_op[0];
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = req_op[1] ? PTR : ACC;
        end
      end
      PTR: begin
        if (mem_resp) begin
          addr_d  = ADDR_W'(mem_rdata);
          cnt_d   = '0;
          state_d = ACC;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACC: begin
        if (mem_resp) begin
          if (wr_q)        rdata_d = '0;
          else if (byte_q) rdata_d = {{(DATA_W-8){1'b0}}, mem_rdata[{lane, 3'b000} +: 8]};
          else             rdata_d = mem_rdata;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them without a clock edge
  assign req_ready       = (state_q == IDLE);
  assign mem_read        = (state_q == PTR) || ((state_q == ACC) && !wr_q);
  assign mem_write       = (state_q == ACC) && wr_q;
  assign mem_address     = ((state_q == ACC) && byte_q) ? addr_q : addr_aligned;
  assign mem_wdata       = byte_q ? {NB{wdata_q[7:0]}} : wdata_q;
  assign mem_byte_enable = (mem_write && byte_q) ? lane_mask : '1;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_err         = rsp_valid && err_q;
  assign rsp_rdata       = rdata_q;
endmodule
